// File: rtl/spi_pkg.sv
// Shared definitions for the full-duplex SPI slave: mode codes, FSM encoding
// and a constant-evaluable ceil(log2) helper.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_slave_fd_if.sv
// Word-level handshake between the SPI slave and the register/command logic.
interface spi_slave_fd_if #(
  parameter int DATA_W = 8
);
  import spi_pkg::*;

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_overrun;
  logic              tx_underrun;

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
  );

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by an edge-detect
// flop that yields single-cycle rise/fall pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit INIT        = 1'b0
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Preloading the idle level keeps reset from manufacturing a phantom edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= {SYNC_STAGES{INIT}};
      prev_q <= INIT;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_fd.sv
// Full-duplex SPI slave, oversampled in the FPGA_clk domain: any CPOL/CPHA,
// MSB/LSB first, valid/ready receive path and a one-word transmit holding register.
module spi_slave_fd
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b1,
  parameter bit CPHA        = 1'b1,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic            FPGA_clk,
  input  logic            FPGA_rst,
  input  logic            SCLK,
  input  logic            SSEL,
  input  logic            MOSI,
  output logic            MISO,
  output logic            miso_oe,
  output logic            busy,
  spi_slave_fd_if.slave   app
);

  localparam int BW = clog2(DATA_W);
  localparam int FW = clog2(SYNC_STAGES + 2) + 1;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ssel_lvl, ssel_rise, ssel_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(CPOL)) u_sclk (
    .clk(FPGA_clk), .srst(FPGA_rst), .d(SCLK),
    .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_ssel (
    .clk(FPGA_clk), .srst(FPGA_rst), .d(SSEL),
    .q(ssel_lvl), .rise(ssel_rise), .fall(ssel_fall)
  );

  // MOSI needs no edge detect; delay it to line up with the SCLK edge pulses.
  logic [SYNC_STAGES:0] mosi_q, mosi_d;
  always_comb mosi_d = {mosi_q[SYNC_STAGES-1:0], MOSI};
  logic mosi_bit;
  assign mosi_bit = mosi_q[SYNC_STAGES-1];

  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  assign sclk_edge   = sclk_rise | sclk_fall;
  assign lead_edge   = sclk_edge & (sclk_lvl != CPOL);
  assign trail_edge  = sclk_edge & (sclk_lvl == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  spi_state_e        state_q, state_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_next;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              arm_q, arm_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              flushed, load;

  // A frame in progress at reset must not be picked up half-way: only arm once
  // the synchronisers have flushed and SSEL has genuinely been seen inactive.
  assign flushed = (flush_q == FW'(SYNC_STAGES + 1));

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    rx_next       = rx_shift_q;
    load          = 1'b0;
    flush_d       = flushed ? flush_q : flush_q + 1'b1;
    arm_d         = arm_q | (flushed & ssel_lvl);

    if (app.rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ssel_fall && arm_q) begin
          state_d    = ACTIVE;
          bitcnt_d   = '0;
          rx_shift_d = '0;
          load       = !CPHA;
        end
      end
      ACTIVE: begin
        if (ssel_rise) begin
          state_d = IDLE;
        end else begin
          if (sample_edge) begin
            rx_next    = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_bit}
                                   : {mosi_bit, rx_shift_q[DATA_W-1:1]};
            rx_shift_d = rx_next;
            if (bitcnt_q == BW'(DATA_W - 1)) begin
              bitcnt_d = '0;
              if (!rx_valid_q || app.rx_ready) begin
                rx_data_d  = rx_next;
                rx_valid_d = 1'b1;
              end else begin
                rx_overrun_d = 1'b1;
              end
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
          // bitcnt == 0 at a shift edge marks the start of a new word in every mode.
          if (shift_edge) begin
            if (bitcnt_q == '0) load = 1'b1;
            else tx_shift_d = MSB_FIRST ? (tx_shift_q << 1) : (tx_shift_q >> 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d    = '0;
        tx_underrun_d = 1'b1;
      end
    end

    // Evaluated after the load so a same-cycle write refills the emptied register.
    if (app.tx_valid && !hold_full_q) begin
      hold_d      = app.tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      state_q       <= IDLE;
      bitcnt_q      <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      arm_q         <= 1'b0;
      flush_q       <= '0;
      mosi_q        <= '0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      arm_q         <= arm_d;
      flush_q       <= flush_d;
      mosi_q        <= mosi_d;
    end
  end

  assign MISO    = (state_q == ACTIVE) && (MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0]);
  assign miso_oe = ~ssel_lvl;
  assign busy    = ~ssel_lvl;

  assign app.tx_ready    = ~hold_full_q;
  assign app.rx_data     = rx_data_q;
  assign app.rx_valid    = rx_valid_q;
  assign app.rx_overrun  = rx_overrun_q;
  assign app.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_fd.sv
// Directed bench: DUT A is mode 3 / 8-bit / MSB first, DUT B is mode 0 / 16-bit / LSB first.
`timescale 1ns/1ps
module tb_spi_slave_fd;
  import spi_pkg::*;

  localparam logic [1:0] MODE_A = SPI_MODE3;
  localparam logic [1:0] MODE_B = SPI_MODE0;
  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sclk_a, ssel_a, mosi_a, miso_a, oe_a, busy_a;
  logic sclk_b, ssel_b, mosi_b, miso_b, oe_b, busy_b;

  spi_slave_fd_if #(.DATA_W(8))  if_a ();
  spi_slave_fd_if #(.DATA_W(16)) if_b ();

  spi_slave_fd #(.DATA_W(8), .CPOL(MODE_A[1]), .CPHA(MODE_A[0]), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_a (
    .FPGA_clk(clk), .FPGA_rst(rst), .SCLK(sclk_a), .SSEL(ssel_a), .MOSI(mosi_a),
    .MISO(miso_a), .miso_oe(oe_a), .busy(busy_a), .app(if_a.slave)
  );

  spi_slave_fd #(.DATA_W(16), .CPOL(MODE_B[1]), .CPHA(MODE_B[0]), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_b (
    .FPGA_clk(clk), .FPGA_rst(rst), .SCLK(sclk_b), .SSEL(ssel_b), .MOSI(mosi_b),
    .MISO(miso_b), .miso_oe(oe_b), .busy(busy_b), .app(if_b.slave)
  );

  int checks = 0;
  int errors = 0;
  int ovr_cnt_a = 0;
  int unr_cnt_a = 0;
  int unr_cnt_b = 0;

  always @(posedge clk) begin
    if (if_a.rx_overrun === 1'b1)  ovr_cnt_a <= ovr_cnt_a + 1;
    if (if_a.tx_underrun === 1'b1) unr_cnt_a <= unr_cnt_a + 1;
    if (if_b.tx_underrun === 1'b1) unr_cnt_b <= unr_cnt_b + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic a_select();
    ssel_a = 1'b0;
    wait_clks(H);
  endtask

  task automatic a_deselect();
    wait_clks(H);
    ssel_a = 1'b1;
    wait_clks(3 * H);
  endtask

  // Mode 3 master: drive on falling SCLK, sample MISO just before rising SCLK.
  task automatic a_word(input logic [7:0] w, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sclk_a = 1'b0;
      mosi_a = w[7-i];
      wait_clks(H);
      got[7-i] = miso_a;
      sclk_a = 1'b1;
      wait_clks(H);
    end
  endtask

  task automatic a_write_tx(input logic [7:0] w);
    if_a.tx_data  = w;
    if_a.tx_valid = 1'b1;
    wait_clks(1);
    if_a.tx_valid = 1'b0;
  endtask

  task automatic a_consume();
    if_a.rx_ready = 1'b1;
    wait_clks(1);
    if_a.rx_ready = 1'b0;
    wait_clks(1);
  endtask

  task automatic test_reset();
    wait_clks(3);
    checks++; if (miso_a !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso_a); end
    checks++; if (oe_a !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", oe_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    checks++; if (if_a.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", if_a.tx_ready); end
    checks++; if (if_a.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", if_a.rx_valid); end
    checks++; if (if_a.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", if_a.rx_data); end
    checks++; if ({if_a.rx_overrun, if_a.tx_underrun} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {if_a.rx_overrun, if_a.tx_underrun}); end
    checks++; if (if_b.rx_data !== 16'h0000) begin errors++; $display("FAIL reset_b_rx_data got %h exp 0000", if_b.rx_data); end
    rst = 1'b0;
    wait_clks(10);
  endtask

  task automatic test_mode3_xfer();
    logic [7:0] got;
    a_write_tx(8'h3C);
    checks++; if (if_a.tx_ready !== 1'b0) begin errors++; $display("FAIL m3_tx_ready_after_write got %b exp 0", if_a.tx_ready); end
    a_select();
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL m3_busy got %b exp 1", busy_a); end
    a_word(8'hA5, 8, got);
    a_deselect();
    $display("mode3 xfer: rx_data=%h rx_valid=%b miso_bits=%h", if_a.rx_data, if_a.rx_valid, got);
    checks++; if (if_a.rx_data !== 8'hA5) begin errors++; $display("FAIL m3_rx_data got %h exp a5", if_a.rx_data); end
    checks++; if (if_a.rx_valid !== 1'b1) begin errors++; $display("FAIL m3_rx_valid got %b exp 1", if_a.rx_valid); end
    checks++; if (got !== 8'h3C) begin errors++; $display("FAIL m3_miso_bits got %h exp 3c", got); end
    checks++; if (if_a.tx_ready !== 1'b1) begin errors++; $display("FAIL m3_tx_ready_after_load got %b exp 1", if_a.tx_ready); end
    a_consume();
    checks++; if (if_a.rx_valid !== 1'b0) begin errors++; $display("FAIL m3_rx_valid_consumed got %b exp 0", if_a.rx_valid); end
  endtask

  task automatic test_mode0_lsb16();
    logic [15:0] w, got;
    logic first;
    int unr0;
    w = 16'h1234;
    got = 16'h0000;
    unr0 = unr_cnt_b;
    if_b.tx_data  = 16'h4C31;
    if_b.tx_valid = 1'b1;
    wait_clks(1);
    if_b.tx_valid = 1'b0;
    ssel_b = 1'b0;
    wait_clks(H);
    first = miso_b;
    for (int i = 0; i < 16; i++) begin
      mosi_b = w[i];
      wait_clks(H);
      got[i] = miso_b;
      sclk_b = 1'b1;
      wait_clks(H);
      sclk_b = 1'b0;
    end
    wait_clks(H);
    ssel_b = 1'b1;
    wait_clks(3 * H);
    $display("mode0 lsb16: rx_data=%h first_miso=%b miso_bits=%h", if_b.rx_data, first, got);
    checks++; if (first !== 1'b1) begin errors++; $display("FAIL m0_first_miso got %b exp 1", first); end
    checks++; if (got !== 16'h4C31) begin errors++; $display("FAIL m0_miso_bits got %h exp 4c31", got); end
    checks++; if (if_b.rx_data !== 16'h1234) begin errors++; $display("FAIL m0_rx_data got %h exp 1234", if_b.rx_data); end
    checks++; if (if_b.rx_valid !== 1'b1) begin errors++; $display("FAIL m0_rx_valid got %b exp 1", if_b.rx_valid); end
    checks++; if (unr_cnt_b - unr0 !== 1) begin errors++; $display("FAIL m0_trailing_underrun got %0d exp 1", unr_cnt_b - unr0); end
    if_b.rx_ready = 1'b1;
    wait_clks(1);
    if_b.rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    int ovr0;
    ovr0 = ovr_cnt_a;
    a_select();
    a_word(8'h11, 8, got);
    a_word(8'h22, 8, got);
    a_deselect();
    $display("back_to_back: rx_data=%h rx_valid=%b overruns=%0d", if_a.rx_data, if_a.rx_valid, ovr_cnt_a - ovr0);
    checks++; if (if_a.rx_data !== 8'h11) begin errors++; $display("FAIL b2b_rx_data got %h exp 11", if_a.rx_data); end
    checks++; if (if_a.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_rx_valid got %b exp 1", if_a.rx_valid); end
    checks++; if (ovr_cnt_a - ovr0 !== 1) begin errors++; $display("FAIL b2b_overrun_count got %0d exp 1", ovr_cnt_a - ovr0); end
    a_consume();
    checks++; if (if_a.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_rx_valid_fall got %b exp 0", if_a.rx_valid); end
  endtask

  task automatic test_underrun();
    logic [7:0] got1, got2;
    int unr0;
    unr0 = unr_cnt_a;
    a_select();
    a_word(8'hC3, 8, got1);
    a_consume();
    a_word(8'hFF, 8, got2);
    a_deselect();
    $display("underrun: miso_w1=%h miso_w2=%h underruns=%0d rx_data=%h", got1, got2, unr_cnt_a - unr0, if_a.rx_data);
    checks++; if (got1 !== 8'h00) begin errors++; $display("FAIL ur_miso_w1 got %h exp 00", got1); end
    checks++; if (got2 !== 8'h00) begin errors++; $display("FAIL ur_miso_w2 got %h exp 00", got2); end
    checks++; if (unr_cnt_a - unr0 !== 2) begin errors++; $display("FAIL ur_count got %0d exp 2", unr_cnt_a - unr0); end
    checks++; if (if_a.rx_data !== 8'hFF) begin errors++; $display("FAIL ur_rx_data got %h exp ff", if_a.rx_data); end
    a_consume();
  endtask

  task automatic test_abort();
    logic [7:0] got;
    int ovr0;
    ovr0 = ovr_cnt_a;
    a_select();
    a_word(8'hFF, 5, got);
    a_deselect();
    checks++; if (if_a.rx_valid !== 1'b0) begin errors++; $display("FAIL abort_no_valid got %b exp 0", if_a.rx_valid); end
    a_select();
    a_word(8'h81, 8, got);
    a_deselect();
    $display("abort: rx_data=%h rx_valid=%b overruns=%0d", if_a.rx_data, if_a.rx_valid, ovr_cnt_a - ovr0);
    checks++; if (if_a.rx_data !== 8'h81) begin errors++; $display("FAIL abort_rx_data got %h exp 81", if_a.rx_data); end
    checks++; if (if_a.rx_valid !== 1'b1) begin errors++; $display("FAIL abort_rx_valid got %b exp 1", if_a.rx_valid); end
    checks++; if (ovr_cnt_a - ovr0 !== 0) begin errors++; $display("FAIL abort_overrun got %0d exp 0", ovr_cnt_a - ovr0); end
  endtask

  task automatic test_reset_midword();
    logic [7:0] got;
    a_write_tx(8'h77);
    a_select();
    a_word(8'hF0, 3, got);
    rst = 1'b1;
    wait_clks(1);
    checks++; if (miso_a !== 1'b0) begin errors++; $display("FAIL rst_mid_miso got %b exp 0", miso_a); end
    checks++; if ({oe_a, busy_a} !== 2'b00) begin errors++; $display("FAIL rst_mid_oe_busy got %b exp 00", {oe_a, busy_a}); end
    checks++; if (if_a.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rx_valid got %b exp 0", if_a.rx_valid); end
    checks++; if (if_a.rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rx_data got %h exp 00", if_a.rx_data); end
    checks++; if (if_a.tx_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_tx_ready got %b exp 1", if_a.tx_ready); end
    wait_clks(2);
    rst = 1'b0;
    a_word(8'hFF, 5, got);
    a_deselect();
    checks++; if (if_a.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ignored got %b exp 0", if_a.rx_valid); end
    a_select();
    a_word(8'h5A, 8, got);
    a_deselect();
    $display("reset_midword: rx_data=%h rx_valid=%b", if_a.rx_data, if_a.rx_valid);
    checks++; if (if_a.rx_data !== 8'h5A) begin errors++; $display("FAIL rst_next_rx_data got %h exp 5a", if_a.rx_data); end
    checks++; if (if_a.rx_valid !== 1'b1) begin errors++; $display("FAIL rst_next_rx_valid got %b exp 1", if_a.rx_valid); end
  endtask

  initial begin
    rst = 1'b1;
    sclk_a = MODE_A[1]; ssel_a = 1'b1; mosi_a = 1'b0;
    sclk_b = MODE_B[1]; ssel_b = 1'b1; mosi_b = 1'b0;
    if_a.tx_data = '0; if_a.tx_valid = 1'b0; if_a.rx_ready = 1'b0;
    if_b.tx_data = '0; if_b.tx_valid = 1'b0; if_b.rx_ready = 1'b0;
    test_reset();
    test_mode3_xfer();
    test_mode0_lsb16();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midword();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_fd.md
# spi_slave_fd

Parametrised full-duplex SPI slave: generalises the receive-only 8-bit slave to any word width, all four CPOL/CPHA modes, MSB- or LSB-first order, and an actively driven MISO fed from a transmit holding register. All SPI pins are oversampled in the FPGA_clk domain. Received words are presented on a valid/ready interface. Sits between the external SPI pins and the register/command logic.

## Interface
- DATA_W, 8: bits per word, 4..32
- CPOL, 1: SCLK idle level
- CPHA, 1: 0 = sample on leading edge; 1 = sample on trailing edge
- MSB_FIRST, 1: 1 = MSB first on both MOSI and MISO
- SYNC_STAGES, 2: synchroniser flops per input, minimum 2
- FPGA_clk  in  1  system clock; the only clock in the block
- FPGA_rst  in  1  synchronous, active-high reset
- SCLK, SSEL, MOSI  in  1  asynchronous SPI pins; SSEL is active low
- MISO  out  1  serial data out; 0 while SSEL is inactive
- miso_oe  out  1  high while SSEL is active, for an external tristate
- tx_data  in  DATA_W  next word to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  holding register is empty
- rx_data  out  DATA_W  last received word
- rx_valid  out  1  held high until rx_ready
- rx_ready  in  1  consumer accepts rx_data
- rx_overrun  out  1  1-cycle pulse: a word completed while rx_valid was high
- tx_underrun  out  1  1-cycle pulse: a word load found the holding register empty
- busy  out  1  synchronised SSEL is active

## Operation
- Each pin passes through SYNC_STAGES flops, then one edge-detect flop. Reset preloads the idle levels: SCLK = CPOL, SSEL = 1, MOSI = 0.
- Leading edge is the first SCLK edge away from CPOL; trailing edge is the return to CPOL.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1.
  - Shift edge: the other one.
- States:
  - IDLE: on the SSEL falling edge, go to ACTIVE and clear the bit counter. If CPHA=0, load the shift register here.
  - ACTIVE: on each sample edge, shift MOSI into rx_shift (left if MSB_FIRST, else right) and increment bitcnt (width $clog2(DATA_W)). When bitcnt = DATA_W-1, complete the word and wrap bitcnt to 0.
  - Any SSEL deassert in ACTIVE returns to IDLE. A partial word is discarded: no rx_valid and no overrun.
- Word completion:
  - rx_valid = 0: rx_data <= rx_shift and rx_valid <= 1.
  - rx_valid = 1 and rx_ready = 0: rx_overrun pulses, the new word is dropped, and rx_data is kept.
  - rx_valid = 1 and rx_ready = 1 in the same cycle: the new word is accepted and there is no overrun.
- TX load point: CPHA=0 loads at SSEL start and at the shift edge that follows each completed word. CPHA=1 loads at the first shift edge of each word.
  - At a load, tx_shift <= holding register if it is full and the holding register empties. Otherwise tx_shift <= 0 and tx_underrun pulses.
  - Other shift edges shift tx_shift.
- MISO = tx_shift MSB (or LSB if MSB_FIRST=0) while active.
- tx_valid && tx_ready writes the holding register. The holding register survives an SSEL abort. A word already in tx_shift is lost on abort.

## Timing
- Reset values: MISO 0, miso_oe 0, tx_ready 1, rx_valid 0, rx_data 0, rx_overrun 0, tx_underrun 0, busy 0. State is IDLE.
- Reset mid-frame: the block stays IDLE until the next SSEL falling edge; the current frame is ignored.
- Edge detect occurs SYNC_STAGES+1 cycles after the pin edge.
- rx_valid rises one cycle after the detected final sample edge.
- MISO updates one cycle after the detected shift edge.
- Requirement: f_FPGA_clk >= 8 x f_SCLK.
- tx_ready drops the cycle after a write and rises the cycle after a load.
- A tx write and a load in the same cycle: the load takes the old holding content first, then the holding register takes the new word.

## Structure
- Shared package spi_pkg holds:
  - mode constants SPI_MODE0..3 as {CPOL,CPHA}
  - state encoding IDLE/ACTIVE
  - the function clog2
- One natural sub-module, spi_sync_edge (parameter SYNC_STAGES, INIT), provides the synchroniser plus rise/fall pulses. It is instantiated for SCLK and SSEL. MOSI uses the synchroniser only.

## Test plan
- Mode 3, DATA_W=8: master sends 0xA5 with tx holding 0x3C -> rx_data = 0xA5 and rx_valid = 1; MISO bits observed = 0x3C.
- Mode 0, DATA_W=16, MSB_FIRST=0: master sends 0x1234 -> rx_data = 0x1234; first MISO bit is present before the first SCLK edge.
- Two back-to-back words 0x11 and 0x22 with rx_ready held 0 -> rx_data = 0x11, one rx_overrun pulse; then rx_ready = 1 -> rx_valid falls.
- No tx_valid during a frame -> MISO = 0 for the word and one tx_underrun pulse per word.
- SSEL raised after 5 bits of 0xFF, then full 0x81 sent -> only 0x81 is reported.
- FPGA_rst asserted mid-word -> all outputs return to reset values; the next full frame 0x5A is received correctly.
